ad9361_spi_slv: RTL

AD9361_SPI_SLV -- requirements
Module: ad9361_spi_slv

---
 rtl/ad9361_spi_pkg.sv | 28 ++
 rtl/ad9361_spi_sync.sv | 30 +++
 rtl/ad9361_spi_slv.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ad9361_spi_pkg.sv
// Shared constants, frame field positions and FSM encoding for the AD9361-style SPI slave.
package ad9361_spi_pkg;
  localparam int CMD_W    = 24;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int WR_BIT   = 23;
  localparam int CNT_MSB  = 22;
  localparam int CNT_LSB  = 20;
  localparam int ADDR_MSB = 17;
  localparam int ADDR_LSB = 8;
  localparam int CNT_W    = 5;
  localparam int HDR_BITS = CMD_W - DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             cs;
    logic             sclk;
    logic             mosi;
  } dbg_t;
endpackage

// File: rtl/ad9361_spi_sync.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall pulses on the synchronized level.
module ad9361_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;
endmodule

// File: rtl/ad9361_spi_slv.sv
// SPI register-access slave: 24-bit frames {wr_rdn, cnt, 2'b00, addr, data}, MSB first, oversampled by sys_clk.
module ad9361_spi_slv
  import ad9361_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              cmd_err,
  output dbg_t              dbg
);
  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CMD_W-2:0]  shift_sr;
  logic [DATA_W-1:0] miso_sr;
  logic              is_rd;
  logic              rd_pend;
  logic              armed;
  logic [SYNC_STAGES:0] flush_sr;

  ad9361_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(sys_clk), .rst(sys_rst), .din(spi_cs), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  ad9361_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(sys_clk), .rst(sys_rst), .din(spi_sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) mosi_chain <= '0;
    else begin
      mosi_chain[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) mosi_chain[i] <= mosi_chain[i-1];
    end
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  // Register port: reg_rd_en is a one-cycle request; reg_rd_data must be valid the cycle after it,
  // and is captured here one cycle later (rd_pend). Write strobe carries addr/data in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_sr    <= '0;
      miso_sr     <= '0;
      is_rd       <= 1'b0;
      rd_pend     <= 1'b0;
      armed       <= 1'b0;
      flush_sr    <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      cmd_err   <= 1'b0;
      rd_pend   <= reg_rd_en;
      if (rd_pend) miso_sr <= reg_rd_data;
      // Only trust a CS fall once CS has been seen high after the synchronizer flushed out of reset.
      flush_sr <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
      if (flush_sr[SYNC_STAGES] && cs_s) armed <= 1'b1;

      if (state != ST_IDLE && cs_s) begin
        state       <= ST_IDLE;
        bit_cnt     <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        if (cs_rise && state != ST_DONE) cmd_err <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            bit_cnt     <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            if (armed && cs_fall) state <= ST_CMD;
          end
          ST_CMD: begin
            if (sclk_rise) begin
              shift_sr <= {shift_sr[CMD_W-3:0], mosi_s};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(HDR_BITS-1)) begin
                state <= ST_DATA;
                is_rd <= ~shift_sr[WR_BIT-DATA_W-1];
                if (shift_sr[CNT_MSB-DATA_W-1 -: 3] != 3'd0) cmd_err <= 1'b1;
                if (!shift_sr[WR_BIT-DATA_W-1]) begin
                  reg_addr  <= {shift_sr[ADDR_MSB-DATA_W-1:0], mosi_s};
                  reg_rd_en <= 1'b1;
                end
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall && is_rd) begin
              spi_miso    <= miso_sr[DATA_W-1];
              spi_miso_oe <= 1'b1;
              miso_sr     <= {miso_sr[DATA_W-2:0], 1'b0};
            end
            if (sclk_rise) begin
              shift_sr <= {shift_sr[CMD_W-3:0], mosi_s};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(CMD_W-1)) begin
                state       <= ST_DONE;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                if (shift_sr[WR_BIT-1]) begin
                  reg_addr    <= shift_sr[ADDR_MSB-1:ADDR_LSB-1];
                  reg_wr_data <= {shift_sr[DATA_W-2:0], mosi_s};
                  reg_wr_en   <= 1'b1;
                end
              end
            end
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dbg = '{state: state, bit_cnt: bit_cnt, cs: cs_s, sclk: sclk_s, mosi: mosi_s};
endmodule
